// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: fetches sequential words from instruction memory and
// buffers them in a 2-entry {pc, inst} FIFO for the decode stage. A taken
// redirect flushes the FIFO and restarts fetch at the word-aligned target.
// At most one memory request is outstanding. A response to a request issued
// before a redirect is discarded.
//
// Ports:
//   clk, rstn            clock, async active-low reset
//   imem_req/imem_addr   fetch request and address (accept = req & ready)
//   imem_ready           memory accepts the request this cycle
//   imem_rvalid/rdata    fetch response
//   redirect/redirect_pc flush and restart fetch at redirect_pc
//   ir_valid/ir/ir_pc    FIFO head presented to decode (NOP when empty)
//   ir_ready             decode consumes the head entry
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  input  logic        ir_ready
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   inflight_pc_q;
  logic [CNT_W-1:0]  count_q;
  logic              rd_ptr_q, wr_ptr_q;
  logic [XLEN-1:0]   fifo_pc   [DEPTH];
  logic [XLEN-1:0]   fifo_inst [DEPTH];

  logic            accept;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_target;

  // Request only when idle, with FIFO space, and not being flushed. Held low
  // during reset even though the reset state would otherwise qualify.
  assign imem_req  = rstn & (state_q == ST_IDLE) & (count_q < CNT_W'(DEPTH)) & ~redirect;
  assign imem_addr = pc_q;
  assign accept    = imem_req & imem_ready;

  // Redirect overrides both push and pop in the same cycle.
  assign push = (state_q == ST_WAIT) & imem_rvalid & ~redirect;
  assign pop  = ir_valid & ir_ready & ~redirect;

  assign redirect_target = redirect_pc & ~XLEN'(3);

  assign ir_valid = (count_q != '0);
  assign ir       = ir_valid ? fifo_inst[rd_ptr_q] : NOP_INST;
  assign ir_pc    = ir_valid ? fifo_pc[rd_ptr_q]   : pc_q;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; any response ends WAIT/DISCARD, redirect without a
  // response turns the outstanding request into one to be dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid)   state_d = ST_IDLE;
        else if (redirect) state_d = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (imem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fetch PC, in-flight PC, FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
    end else if (redirect) begin
      pc_q     <= redirect_target;
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (accept) begin
        pc_q          <= pc_q + XLEN'(4);
        inflight_pc_q <= pc_q;
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_q]   <= inflight_pc_q;
      fifo_inst[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002: Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), is the instruction presented to decode when no valid entry exists.
REQ-003: clk  input  1  single clock; all state on rising edge.
REQ-004: rstn  input  1  reset, asynchronous, active-low.
REQ-005: imem_req  output  1  fetch request to instruction memory.
REQ-006: imem_addr  output  32  fetch address; valid while imem_req=1.
REQ-007: imem_ready  input  1  memory accepts request this cycle (accept = imem_req & imem_ready).
REQ-008: imem_rvalid  input  1  response data valid; arrives at least 1 cycle after accept.
REQ-009: imem_rdata  input  32  fetched instruction word.
REQ-010: redirect  input  1  branch/jump resolved taken; flush and restart fetch.
REQ-011: redirect_pc  input  32  new fetch target.
REQ-012: ir_valid  output  1  entry available to decode.
REQ-013: ir  output  32  instruction to decode stage (feeds the control decoder IR input).
REQ-014: ir_pc  output  32  address of ir.
REQ-015: ir_ready  input  1  decode consumes entry this cycle (pop = ir_valid & ir_ready).

Function
REQ-016: Block SHALL hold fetch PC register, 2-entry FIFO of {pc, inst}, 2-bit occupancy count, and 3-state FSM: IDLE, WAIT, DISCARD.
REQ-017: At most one memory request SHALL be outstanding.
REQ-018: imem_req SHALL = (state==IDLE) & (count<2) & ~redirect; imem_addr SHALL = fetch PC.
REQ-019: On accept, fetch PC SHALL advance by 4 (modulo 2^32, wraps 32'hFFFF_FFFC -> 0), the address SHALL be latched as in-flight pc, and state SHALL go IDLE -> WAIT.
REQ-020: In WAIT with imem_rvalid=1 and no redirect: push {in-flight pc, imem_rdata}, state -> IDLE; next request no earlier than the following cycle.
REQ-021: imem_rvalid outside WAIT/DISCARD SHALL be ignored.
REQ-022: FIFO SHALL be first-in-first-out; ir/ir_pc SHALL be the head entry combinationally; ir_valid = (count!=0).
REQ-023: When count==0, ir SHALL = NOP_INST and ir_pc SHALL = fetch PC.
REQ-024: Push and pop in the same cycle SHALL leave count unchanged and keep order; push never occurs at count==2 (guaranteed by REQ-018).
REQ-025: redirect SHALL have priority over every other event in the same cycle: FIFO cleared (count=0, any pop ignored), fetch PC = {redirect_pc[31:2], 2'b00}.
REQ-026: Redirect in IDLE: state stays IDLE; no request that cycle.
REQ-027: Redirect in WAIT with imem_rvalid=1: response dropped, state -> IDLE.
REQ-028: Redirect in WAIT with imem_rvalid=0: state -> DISCARD.
REQ-029: In DISCARD, the next imem_rvalid SHALL be dropped and state -> IDLE; a redirect in DISCARD SHALL update fetch PC and remain DISCARD (or go IDLE if imem_rvalid same cycle).
REQ-030: Fetch latency: first ir_valid no earlier than 2 cycles after the first accept with 1-cycle memory.

Reset
REQ-031: While rstn=0: fetch PC=RESET_PC, count=0, state=IDLE, FIFO contents don't-care; outputs imem_req=0, ir_valid=0, ir=NOP_INST, ir_pc=RESET_PC.
REQ-032: Reset assertion mid-request SHALL abandon the in-flight request; responses arriving after rstn release with state IDLE SHALL be ignored.
REQ-033: First request SHALL issue in the first cycle after rstn release with imem_addr=RESET_PC.

Verification
REQ-034: Reset release, imem_ready=1, 1-cycle rvalid returning addr-based data, ir_ready=1 -> ir_pc sequence 0x0,0x4,0x8 with matching ir, no gaps beyond one idle cycle per fetch.
REQ-035: ir_ready=0 held -> exactly 2 entries buffered (pc 0x0, 0x4), imem_req=0 thereafter; ir_ready=1 -> pops in order, fetching resumes at 0x8.
REQ-036: Redirect to 0x0000_0103 while in WAIT, rvalid arriving next cycle with 0xDEADBEEF -> data dropped, ir_valid=0, next imem_addr=0x0000_0100.
REQ-037: Redirect in same cycle as rvalid and as pop with count=2 -> count=0, no push, fetch resumes at redirect target.
REQ-038: Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
REQ-039: rstn pulsed low for 1 cycle while in WAIT, stale rvalid after release -> ignored, first request at RESET_PC, ir=NOP_INST until first valid fetch.
